control_merge_dataless: RTL and testbench
=========================================

# control_merge_dataless

Dataless control merge: accepts a token from any of SIZE control inputs and emits one token on `outs`. It also emits, on `index`, the number of the input that supplied the token. It sits directly upstream of `mux_dataless`: its `index` channel drives the mux's select channel, so downstream muxes pick the data input matching the control path taken. Internally it contains a fixed-priority arbiter, a one-slot transparent buffer (TEHB) holding the chosen index, and a two-way eager fork.

## Interface
- `SIZE`, default 2: number of control input channels, ≥1.
- `INDEX_TYPE`, default 1: width of `index`, ≥ max(1, clog2(SIZE)).

- `clk` input 1: clock, all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-low (asserted when 0).
- `ins_valid` input SIZE: per-input valid.
- `ins_ready` output SIZE: per-input ready.
- `outs_valid` output 1: dataless output token valid.
- `outs_ready` input 1: output channel ready.
- `index` output INDEX_TYPE: number of the winning input.
- `index_valid` output 1: index channel valid.
- `index_ready` input 1: index channel ready.

## Operation
- Arbiter (combinational):
  - `sel` = lowest i with `ins_valid[i]`=1; `sel`=0 when none valid.
  - `m_valid` = |`ins_valid`.
  - `ins_ready[i]` = `tehb_ready` & (i == `sel`); non-selected inputs are never ready.
  - Exactly one input is consumed per accepted token; lower index wins on simultaneous valids.
- TEHB (one slot, registers `full`, `idx_reg`):
  - `tehb_ready` = ~`full`.
  - `v` = `full` | `m_valid`; `d` = `full` ? `idx_reg` : `sel`.
  - If ~`full` & `m_valid` & ~`f_ready`: `idx_reg` ← `sel`, `full` ← 1.
  - If `full` & `f_ready`: `full` ← 0.
  - `sel` is zero-extended to INDEX_TYPE.
- Eager fork (registers `sent[1:0]`: bit0 = outs, bit1 = index):
  - `outs_valid` = `v` & ~`sent[0]`; `index_valid` = `v` & ~`sent[1]`; `index` = `d`.
  - `done[0]` = `sent[0]` | (`outs_valid` & `outs_ready`); `done[1]` likewise with `index_valid` & `index_ready`.
  - `f_ready` = `done[0]` & `done[1]`.
  - Next state: `sent` ← `f_ready` ? 0 : `done`.
- Boundary cases:
  - Both consumers ready in the same cycle: token retires in one cycle, `sent` stays 0.
  - One consumer stalls: the other side's handshake completes once and is not re-offered; the token stays in TEHB until the stalled side accepts.
  - TEHB full: all `ins_ready`=0. The next input is accepted only in the cycle after the slot drains.
  - SIZE=1: `index` is constant 0.

## Timing
- Reset (`rst`=0 at a clock edge): `full`←0, `idx_reg`←0, `sent`←00.
- Outputs with `ins_valid`=0 after reset: `outs_valid`=0, `index_valid`=0, `index`=0, `ins_ready`=…01.
- Reset mid-operation discards any buffered or partially forked token; no output is re-issued after reset.
- Latency 0: input valid to `outs_valid`/`index_valid` in the same cycle when TEHB is empty.
- Throughput: 1 token/cycle while both consumers are ready.
- Combinational paths:
  - `ins_valid` → `outs_valid`, `index_valid`, `index`.
  - `outs_ready`/`index_ready` → `ins_ready` only through `full` (registered); no ready→ready combinational path.
- Valid/ready rules: a valid, once asserted, is held with a stable `index` until accepted; acceptance happens at a clock edge where valid & ready.

## Structure
- Shared handshake package: function `lowest_set_index(vec)` returning INDEX_TYPE bits (0 when vec=0).
- One sub-module: `tehb`, parameterized by DATA_TYPE=INDEX_TYPE, with `clk`/`rst` (same reset polarity), ins/outs channels. Arbiter and fork are inline.

## Test plan
- Single token: SIZE=2, `ins_valid`=10, both readies=1 → same cycle `outs_valid`=1, `index`=1, `index_valid`=1, `ins_ready`=10; `full`/`sent` stay 0.
- Priority: `ins_valid`=11 for 2 cycles, readies=1 → cycle 1 `index`=0, `ins_ready`=01; cycle 2 (input 0 dropped) `index`=1.
- Buffering: `ins_valid`=01, `outs_ready`=`index_ready`=0 → token captured, `ins_ready`=00 next cycle. A new `ins_valid`=10 is blocked; after both readies=1 for a cycle, the buffered `index`=0 is emitted first, then `index`=1.
- Partial fork: token present, `outs_ready`=1, `index_ready`=0 for 3 cycles → `outs_valid` high 1 cycle only, `index_valid` held with `index` stable. Then `index_ready`=1 → token retires, `sent`=00.
- Reset mid-op: TEHB full, `sent`=01, `rst`=0 one edge with `ins_valid`=0 → all valids 0, `index`=0, `ins_ready`=01.
- SIZE=4, INDEX_TYPE=2: `ins_valid`=1000 → `index`=3.

Source files
------------

// File: rtl/control_merge_dataless_pkg.sv
// Shared handshake helpers for the dataless control merge and its one-slot buffer.
package control_merge_dataless_pkg;

    localparam int MAX_W = 32;

    localparam int FORK_OUTS  = 0;
    localparam int FORK_INDEX = 1;

    typedef logic [1:0] fork_mask_t;

    // Position of the lowest set bit; 0 when no bit is set.
    function automatic logic [MAX_W-1:0] lowest_set_index(input logic [MAX_W-1:0] vec);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r = MAX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/control_merge_dataless_tehb.sv
// One-slot transparent elastic buffer: passes data straight through, holds it only on stall.
module tehb #(
    parameter int DATA_TYPE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] ins,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    output logic [DATA_TYPE-1:0] outs,
    output logic                 outs_valid,
    input  logic                 outs_ready
);

    logic                 full_q;
    logic [DATA_TYPE-1:0] data_q;

    assign ins_ready  = ~full_q;
    assign outs_valid = full_q | ins_valid;
    assign outs       = full_q ? data_q : ins;

    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (!full_q && ins_valid && !outs_ready) begin
            full_q <= 1'b1;
            data_q <= ins;
        end else if (full_q && outs_ready) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/control_merge_dataless.sv
// Dataless control merge: priority-picks one valid input, emits a token plus the winner's index.
module control_merge_dataless
    import control_merge_dataless_pkg::*;
#(
    parameter int SIZE       = 2,
    parameter int INDEX_TYPE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SIZE-1:0]       ins_valid,
    output logic [SIZE-1:0]       ins_ready,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic [INDEX_TYPE-1:0] index,
    output logic                  index_valid,
    input  logic                  index_ready
);

    logic [INDEX_TYPE-1:0] sel;
    logic                  m_valid;
    logic                  tehb_ready;
    logic                  v;
    logic [INDEX_TYPE-1:0] d;
    logic                  f_ready;
    fork_mask_t            done;
    fork_mask_t            sent_q;
    fork_mask_t            sent_d;

    assign sel     = INDEX_TYPE'(lowest_set_index(MAX_W'(ins_valid)));
    assign m_valid = |ins_valid;

    // Only the winner sees ready, so exactly one input is consumed per token.
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_ins_ready
        assign ins_ready[gi] = tehb_ready & (sel == INDEX_TYPE'(gi));
    end

    tehb #(
        .DATA_TYPE(INDEX_TYPE)
    ) u_tehb (
        .clk        (clk),
        .rst        (rst),
        .ins        (sel),
        .ins_valid  (m_valid),
        .ins_ready  (tehb_ready),
        .outs       (d),
        .outs_valid (v),
        .outs_ready (f_ready)
    );

    assign outs_valid  = v & ~sent_q[FORK_OUTS];
    assign index_valid = v & ~sent_q[FORK_INDEX];
    assign index       = d;

    assign done[FORK_OUTS]  = sent_q[FORK_OUTS]  | (outs_valid & outs_ready);
    assign done[FORK_INDEX] = sent_q[FORK_INDEX] | (index_valid & index_ready);
    assign f_ready          = &done;
    assign sent_d           = f_ready ? '0 : done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sent_q <= '0;
        end else begin
            sent_q <= sent_d;
        end
    end

endmodule

// File: tb/tb_control_merge_dataless.sv
// Cycle-level scoreboard bench for control_merge_dataless (SIZE=2 and SIZE=4 instances).
module tb_control_merge_dataless;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] iv2 = '0;
    logic [3:0] iv4 = '0;
    logic       o_rdy = 1'b0;
    logic       i_rdy = 1'b0;

    logic [1:0] ir2;
    logic       ov2, ivd2;
    logic       idx2;
    logic [3:0] ir4;
    logic       ov4, ivd4;
    logic [1:0] idx4;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string    name;
        bit       dut;
        bit       ov;
        bit       ivd;
        bit [1:0] idx;
        bit [3:0] ir;
    } exp_t;

    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    control_merge_dataless #(.SIZE(2), .INDEX_TYPE(1)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .ins_valid   (iv2),
        .ins_ready   (ir2),
        .outs_valid  (ov2),
        .outs_ready  (o_rdy),
        .index       (idx2),
        .index_valid (ivd2),
        .index_ready (i_rdy)
    );

    control_merge_dataless #(.SIZE(4), .INDEX_TYPE(2)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .ins_valid   (iv4),
        .ins_ready   (ir4),
        .outs_valid  (ov4),
        .outs_ready  (o_rdy),
        .index       (idx4),
        .index_valid (ivd4),
        .index_ready (i_rdy)
    );

    task automatic step(input bit r, input bit d, input logic [3:0] iv, input bit orr,
                        input bit irr, input bit chk, input string nm, input bit eov,
                        input bit eivd, input logic [1:0] eidx, input logic [3:0] eir);
        exp_t x;
        @(posedge clk);
        #1;
        rst   = r;
        o_rdy = orr;
        i_rdy = irr;
        if (d) begin
            iv4 = iv;
            iv2 = '0;
        end else begin
            iv2 = iv[1:0];
            iv4 = '0;
        end
        if (chk) begin
            x.name = nm;
            x.dut  = d;
            x.ov   = eov;
            x.ivd  = eivd;
            x.idx  = eidx;
            x.ir   = eir;
            q.push_back(x);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            bit       a_ov, a_ivd;
            bit [1:0] a_idx;
            bit [3:0] a_ir;
            e = q.pop_front();
            if (e.dut) begin
                a_ov = ov4; a_ivd = ivd4; a_idx = idx4; a_ir = ir4;
            end else begin
                a_ov = ov2; a_ivd = ivd2; a_idx = {1'b0, idx2}; a_ir = {2'b00, ir2};
            end
            n_tests++;
            if (a_ov !== e.ov || a_ivd !== e.ivd || a_idx !== e.idx || a_ir !== e.ir) begin
                n_fail++;
                $display("FAIL %s: got outs_valid=%0b index_valid=%0b index=%0d ins_ready=%b, expected outs_valid=%0b index_valid=%0b index=%0d ins_ready=%b",
                         e.name, a_ov, a_ivd, a_idx, a_ir, e.ov, e.ivd, e.idx, e.ir);
            end else begin
                $display("[TB] %s: outs_valid=%0b index_valid=%0b index=%0d ins_ready=%b",
                         e.name, a_ov, a_ivd, a_idx, a_ir);
            end
        end
    end

    initial begin
        //    rst dut ins_v    or  ir chk name            ov ivd idx ins_ready
        step(0, 0, 4'b0000, 1, 1, 0, "reset",          0, 0, 0, 4'b0000);
        step(1, 0, 4'b0000, 1, 1, 1, "reset_state",    0, 0, 0, 4'b0001);
        step(1, 0, 4'b0010, 1, 1, 1, "single_token",   1, 1, 1, 4'b0010);
        step(1, 0, 4'b0000, 1, 1, 1, "single_idle",    0, 0, 0, 4'b0001);
        step(1, 0, 4'b0011, 1, 1, 1, "prio_both",      1, 1, 0, 4'b0001);
        step(1, 0, 4'b0010, 1, 1, 1, "prio_second",    1, 1, 1, 4'b0010);
        step(1, 0, 4'b0001, 0, 0, 1, "buf_capture",    1, 1, 0, 4'b0001);
        step(1, 0, 4'b0010, 0, 0, 1, "buf_blocked",    1, 1, 0, 4'b0000);
        step(1, 0, 4'b0010, 1, 1, 1, "buf_drain",      1, 1, 0, 4'b0000);
        step(1, 0, 4'b0010, 1, 1, 1, "buf_next",       1, 1, 1, 4'b0010);
        step(1, 0, 4'b0001, 1, 0, 1, "fork_first",     1, 1, 0, 4'b0001);
        step(1, 0, 4'b0000, 1, 0, 1, "fork_hold1",     0, 1, 0, 4'b0000);
        step(1, 0, 4'b0000, 1, 0, 1, "fork_hold2",     0, 1, 0, 4'b0000);
        step(1, 0, 4'b0000, 1, 1, 1, "fork_retire",    0, 1, 0, 4'b0000);
        step(1, 0, 4'b0000, 1, 1, 1, "fork_idle",      0, 0, 0, 4'b0001);
        step(1, 0, 4'b0001, 1, 0, 1, "midop_load",     1, 1, 0, 4'b0001);
        step(0, 0, 4'b0000, 0, 0, 0, "midop_reset",    0, 0, 0, 4'b0000);
        step(1, 0, 4'b0000, 1, 1, 1, "midop_after",    0, 0, 0, 4'b0001);
        step(1, 1, 4'b1000, 1, 1, 1, "size4_top",      1, 1, 3, 4'b1000);
        step(1, 1, 4'b0110, 1, 1, 1, "size4_prio",     1, 1, 1, 4'b0010);
        step(1, 1, 4'b0000, 1, 1, 1, "size4_idle",     0, 0, 0, 4'b0001);

        for (int k = 0; k < 10 && q.size() != 0; k++) begin
            @(posedge clk);
        end
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
